// File: rtl/lbm_pkg.sv
// Shared D2Q9 lattice constants, Q8.56 fixed-point literals and state encodings.
package lbm_pkg;

    localparam int Q     = 9;
    localparam int WIDTH = 64;

    localparam logic [WIDTH-1:0] FX_ONE     = 64'h0100_0000_0000_0000;
    localparam logic [WIDTH-1:0] FX_NEG_ONE = 64'hFF00_0000_0000_0000;
    localparam logic [WIDTH-1:0] FX_ZERO    = 64'h0000_0000_0000_0000;

    typedef enum logic [1:0] {CY_ZERO, CY_POS, CY_NEG} cy_code_t;

    typedef enum logic {ACCUM, HOLD} state_t;

endpackage

// File: rtl/cy_decode.sv
// Maps one Q8.56 lattice y-velocity entry to a sign code; anything other than
// exactly +1.0, -1.0 or 0.0 is treated as zero and flagged illegal. Combinational.
module cy_decode
    import lbm_pkg::*;
#(
    parameter int WIDTH = lbm_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] entry,
    output cy_code_t         code,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] ENT_POS  = {8'h01, {(WIDTH-8){1'b0}}};
    localparam logic [WIDTH-1:0] ENT_NEG  = {8'hFF, {(WIDTH-8){1'b0}}};
    localparam logic [WIDTH-1:0] ENT_ZERO = '0;

    always_comb begin
        code    = CY_ZERO;
        illegal = 1'b0;
        if (entry == ENT_POS) begin
            code = CY_POS;
        end else if (entry == ENT_NEG) begin
            code = CY_NEG;
        end else if (entry != ENT_ZERO) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/cy_moment_acc.sv
// Streams nine f_i beats per node and returns j_y = sum(cy_i*f_i); result valid the cycle after beat 8,
// held with input stalled until Out_Ready. Define CY_MOMENT_SAT_EN to saturate Jy_Out instead of wrapping.
module cy_moment_acc
    import lbm_pkg::*;
#(
    parameter int WIDTH = lbm_pkg::WIDTH,
    parameter int Q     = lbm_pkg::Q
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [WIDTH*Q-1:0] Cy_In,
    input  logic               F_Valid,
    output logic               F_Ready,
    input  logic [WIDTH-1:0]   F_Data,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [WIDTH-1:0]   Jy_Out,
    output logic               Cy_Err
);

    localparam int CW = $clog2(Q);
    localparam int AW = WIDTH + 4;

    state_t                state, next_state;
    logic [CW-1:0]         cnt;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  f_ext;
    logic signed [AW-1:0]  term;
    logic [WIDTH-1:0]      cy_entry [Q];
    cy_code_t              cy_code;
    logic                  cy_illegal;
    logic                  beat_acc;
    logic                  last_beat;
    logic                  out_take;
    logic [WIDTH-1:0]      jy_red;

    for (genvar i = 0; i < Q; i++) begin : g_entry
        assign cy_entry[i] = Cy_In[WIDTH*i +: WIDTH];
    end

    cy_decode #(.WIDTH(WIDTH)) u_decode (
        .entry   (cy_entry[cnt]),
        .code    (cy_code),
        .illegal (cy_illegal)
    );

    assign f_ext     = {{4{F_Data[WIDTH-1]}}, F_Data};
    assign last_beat = (cnt == CW'(Q - 1));

    always_comb begin
        term = '0;
        case (cy_code)
            CY_POS:  term = f_ext;
            CY_NEG:  term = -f_ext;
            default: term = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        F_Ready    = 1'b0;
        Out_Valid  = 1'b0;
        beat_acc   = 1'b0;
        out_take   = 1'b0;
        case (state)
            ACCUM: begin
                F_Ready  = !Reset;
                beat_acc = F_Valid && !Reset;
                if (beat_acc && last_beat) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                Out_Valid = 1'b1;
                out_take  = Out_Ready;
                if (Out_Ready) begin
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt    <= '0;
            acc    <= '0;
            Cy_Err <= 1'b0;
        end else begin
            if (beat_acc) begin
                acc <= acc + term;
                cnt <= last_beat ? '0 : cnt + CW'(1);
                if (cy_illegal) begin
                    Cy_Err <= 1'b1;
                end
            end else if (out_take) begin
                acc <= '0;
            end
        end
    end

`ifdef CY_MOMENT_SAT_EN
    // Top five bits must agree for acc to fit the signed WIDTH range.
    always_comb begin
        jy_red = acc[WIDTH-1:0];
        if (!acc[AW-1] && (acc[AW-1:WIDTH-1] != '0)) begin
            jy_red = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (acc[AW-1] && (acc[AW-1:WIDTH-1] != '1)) begin
            jy_red = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign jy_red = acc[WIDTH-1:0];
`endif

    assign Jy_Out = (state == HOLD) ? jy_red : '0;

endmodule

// File: tb/tb_cy_moment_acc.sv
// Randomized and directed checks of cy_moment_acc against a plain-arithmetic reference model.
module tb_cy_moment_acc;
    import lbm_pkg::*;

    localparam int W  = 64;
    localparam int NQ = 9;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [W*NQ-1:0] Cy_In;
    logic            F_Valid;
    logic            F_Ready;
    logic [W-1:0]    F_Data;
    logic            Out_Valid;
    logic            Out_Ready;
    logic [W-1:0]    Jy_Out;
    logic            Cy_Err;

    int tests = 0;
    int fails = 0;

    logic [W*NQ-1:0] cy_std;
    logic [W-1:0]    fv [NQ];

    cy_moment_acc #(.WIDTH(W), .Q(NQ)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Cy_In     (Cy_In),
        .F_Valid   (F_Valid),
        .F_Ready   (F_Ready),
        .F_Data    (F_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Jy_Out    (Jy_Out),
        .Cy_Err    (Cy_Err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] ent(input logic [7:0] b);
        return {b, 56'h0};
    endfunction

    // Reference: decode by exact value, sum in wide signed arithmetic, then wrap or saturate.
    function automatic logic [W-1:0] model(input logic [W*NQ-1:0] cy, input logic [W-1:0] f [NQ]);
        logic signed [79:0] s;
        logic signed [79:0] t;
        logic [W-1:0] e;
        s = '0;
        for (int i = 0; i < NQ; i++) begin
            e = cy[W*i +: W];
            t = $signed({{16{f[i][W-1]}}, f[i]});
            if (e == FX_ONE) s = s + t;
            else if (e == FX_NEG_ONE) s = s - t;
        end
`ifdef CY_MOMENT_SAT_EN
        if (s > 80'sh7FFF_FFFF_FFFF_FFFF) return 64'h7FFF_FFFF_FFFF_FFFF;
        if (s < -80'sh8000_0000_0000_0000) return 64'h8000_0000_0000_0000;
`endif
        return s[W-1:0];
    endfunction

    task automatic send_node(input logic [W-1:0] f [NQ], input int gap_pct);
        int i;
        int cyc;
        logic take;
        i = 0;
        cyc = 0;
        while (i < NQ && cyc < 500) begin
            @(negedge Clk);
            F_Valid = ($urandom_range(99) >= gap_pct);
            F_Data  = f[i];
            take    = F_Valid && F_Ready;
            @(posedge Clk);
            if (take) i++;
            cyc++;
        end
        #1 F_Valid = 1'b0;
        if (i < NQ) begin
            tests++; fails++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", i, NQ);
        end
    endtask

    task automatic get_result(input string name, input logic [W-1:0] exp, input int hold);
        int cyc;
        cyc = 0;
        @(negedge Clk);
        while (!Out_Valid && cyc < 50) begin
            @(negedge Clk);
            cyc++;
        end
        tests++;
        if (!Out_Valid) begin
            fails++;
            $display("FAIL %s_valid_timeout: Out_Valid=%b required 1", name, Out_Valid);
        end else if (Jy_Out !== exp) begin
            fails++;
            $display("FAIL %s: Jy_Out=%h required %h", name, Jy_Out, exp);
        end
        repeat (hold) @(negedge Clk);
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1 Out_Ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (F_Ready !== 1'b0 || Out_Valid !== 1'b0 || Jy_Out !== '0 || Cy_Err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b vld=%b jy=%h err=%b required 0 0 0 0",
                     F_Ready, Out_Valid, Jy_Out, Cy_Err);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        tests++;
        if (F_Ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_rdy: F_Ready=%b required 1", F_Ready);
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < NQ; i++) begin
            @(negedge Clk);
            F_Valid = 1'b1;
            F_Data  = FX_ONE;
            if (i == NQ - 1) begin
                tests++;
                if (Out_Valid !== 1'b0) begin
                    fails++;
                    $display("FAIL ones_early_valid: Out_Valid=%b required 0", Out_Valid);
                end
            end
        end
        @(negedge Clk);
        F_Valid = 1'b0;
        tests++;
        if (Out_Valid !== 1'b1 || Jy_Out !== '0 || Cy_Err !== 1'b0) begin
            fails++;
            $display("FAIL ones_cycle10: vld=%b jy=%h err=%b required 1 0 0", Out_Valid, Jy_Out, Cy_Err);
        end
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1 Out_Ready = 1'b0;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NQ; i++) fv[i] = ent(8'(i));
        send_node(fv, 0);
        get_result("ramp", 64'h0600_0000_0000_0000, 0);
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp;
`ifdef CY_MOMENT_SAT_EN
        exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp = 64'h7FFF_FFFF_FFFF_FFFD;
`endif
        for (int i = 0; i < NQ; i++) fv[i] = '0;
        fv[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        fv[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        fv[6] = 64'h7FFF_FFFF_FFFF_FFFF;
        send_node(fv, 20);
        get_result("overflow", exp, 1);
    endtask

    task automatic test_backpressure();
        int cyc;
        for (int i = 0; i < NQ; i++) fv[i] = ent(8'(i));
        send_node(fv, 0);
        cyc = 0;
        @(negedge Clk);
        while (!Out_Valid && cyc < 50) begin
            @(negedge Clk);
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            F_Valid = 1'b1;
            F_Data  = FX_ONE;
            tests++;
            if (Out_Valid !== 1'b1 || F_Ready !== 1'b0 || Jy_Out !== 64'h0600_0000_0000_0000) begin
                fails++;
                $display("FAIL backpressure_hold%0d: vld=%b rdy=%b jy=%h required 1 0 0600000000000000",
                         k, Out_Valid, F_Ready, Jy_Out);
            end
            @(negedge Clk);
        end
        F_Valid = 1'b0;
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1 Out_Ready = 1'b0;
        for (int i = 0; i < NQ; i++) fv[i] = FX_ONE;
        send_node(fv, 0);
        get_result("after_backpressure", '0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            F_Valid = 1'b1;
            F_Data  = (i == 0) ? ent(8'h05) : '0;
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        tests++;
        if (F_Ready !== 1'b0 || Out_Valid !== 1'b0 || Jy_Out !== '0 || Cy_Err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs: rdy=%b vld=%b jy=%h err=%b required 0 0 0 0",
                     F_Ready, Out_Valid, Jy_Out, Cy_Err);
        end
        F_Valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < NQ; i++) fv[i] = FX_ONE;
        send_node(fv, 0);
        get_result("reset_mid_no_stale", '0, 0);
    endtask

    task automatic test_random();
        logic [W*NQ-1:0] cy;
        logic [W-1:0]    exp;
        logic [7:0]      codes [3];
        codes[0] = 8'h00;
        codes[1] = 8'h01;
        codes[2] = 8'hFF;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NQ; i++) begin
                cy[W*i +: W] = ent(codes[$urandom_range(2)]);
                case ($urandom_range(3))
                    0:       fv[i] = 64'h7FFF_FFFF_FFFF_FFFF;
                    1:       fv[i] = 64'h8000_0000_0000_0000;
                    default: fv[i] = {$urandom, $urandom};
                endcase
            end
            Cy_In = cy;
            exp = model(cy, fv);
            send_node(fv, 30);
            get_result("random", exp, $urandom_range(3));
            tests++;
            if (Cy_Err !== 1'b0) begin
                fails++;
                $display("FAIL random_cy_err: Cy_Err=%b required 0", Cy_Err);
            end
        end
        Cy_In = cy_std;
    endtask

    task automatic test_cy_err();
        logic [W*NQ-1:0] cy;
        cy = cy_std;
        cy[W*5 +: W] = ent(8'h02);
        Cy_In = cy;
        for (int i = 0; i < NQ; i++) fv[i] = FX_ONE;
        send_node(fv, 10);
        get_result("cy_err_sum", model(cy, fv), 0);
        tests++;
        if (Cy_Err !== 1'b1) begin
            fails++;
            $display("FAIL cy_err_set: Cy_Err=%b required 1", Cy_Err);
        end
        Cy_In = cy_std;
        send_node(fv, 0);
        get_result("cy_err_clean_sum", '0, 0);
        tests++;
        if (Cy_Err !== 1'b1) begin
            fails++;
            $display("FAIL cy_err_sticky: Cy_Err=%b required 1", Cy_Err);
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        tests++;
        if (Cy_Err !== 1'b0) begin
            fails++;
            $display("FAIL cy_err_reset: Cy_Err=%b required 0", Cy_Err);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        cy_std = '0;
        cy_std[W*0 +: W] = ent(8'hFF);
        cy_std[W*1 +: W] = ent(8'hFF);
        cy_std[W*2 +: W] = ent(8'h01);
        cy_std[W*3 +: W] = ent(8'h01);
        cy_std[W*4 +: W] = ent(8'hFF);
        cy_std[W*5 +: W] = ent(8'h00);
        cy_std[W*6 +: W] = ent(8'h01);
        cy_std[W*7 +: W] = ent(8'h00);
        cy_std[W*8 +: W] = ent(8'h00);
        Cy_In     = cy_std;
        Reset     = 1'b1;
        F_Valid   = 1'b0;
        F_Data    = '0;
        Out_Ready = 1'b0;
        #1;
        test_reset();
        test_all_ones();
        test_ramp();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_cy_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cy_moment_acc.md
# cy_moment_acc

Streaming y-momentum accumulator for the D2Q9 lattice. It consumes the nine distribution values f_0..f_8 of one node, one per beat, and weights each by the matching lattice y-velocity taken from the packed 9-entry velocity vector. It returns j_y = sum(cy_i * f_i) per node. It sits downstream of the velocity-constant register, reads its packed output, and feeds the macroscopic-variable stage.

## Interface
- WIDTH, 64: bits per fixed-point value; signed Q8.56 (8 integer bits, 56 fraction bits).
- Q, 9: number of lattice directions per node.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Cy_In  in  WIDTH*Q  packed y-velocities; entry i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i]; quasi-static.
- F_Valid  in  1  the current F_Data beat is valid.
- F_Ready  out  1  the block accepts a beat this cycle.
- F_Data  in  WIDTH  signed f_i in Q8.56; beats arrive in order i = 0..Q-1.
- Out_Valid  out  1  Jy_Out holds a completed node result.
- Out_Ready  in  1  the downstream stage takes the result.
- Jy_Out  out  WIDTH  signed j_y in Q8.56.
- Cy_Err  out  1  sticky flag: an illegal Cy_In entry was decoded.

## Operation
- Decoding of each Cy_In entry, by its integer byte (top 8 bits) with all fraction bits zero:
  - 0x01 decodes to +1.
  - 0xFF decodes to -1.
  - 0x00 decodes to 0.
  - Any other value decodes to 0 and sets Cy_Err.
- FSM states: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - F_Ready = 1, except while Reset is high.
  - On each accepted beat (F_Valid & F_Ready), acc += f, -f or 0 according to cy[cnt], then cnt++.
  - Cy_In is sampled on the accepting edge only.
  - On the beat where cnt = Q-1, the state moves to HOLD and cnt wraps to 0.
- HOLD:
  - F_Ready = 0 and Out_Valid = 1.
  - Jy_Out = acc reduced to WIDTH bits (see Configuration).
  - On Out_Valid & Out_Ready, the state moves to ACCUM and acc clears to 0.
- Accumulator width is WIDTH+4 bits, signed. Nine terms of magnitude at most 2^63 cannot overflow it.
- Cy_Err clears only on Reset.
- Reset values: state ACCUM, cnt 0, acc 0, Out_Valid 0, Jy_Out 0, Cy_Err 0, F_Ready 0 while Reset is asserted.

## Timing
- Out_Valid rises on the cycle after the 9th beat is accepted.
- Minimum node period is Q+1 = 10 cycles: 9 beats plus 1 HOLD cycle.
- Gaps in F_Valid stall accumulation. The counter and acc hold their values.
- Under back-pressure (Out_Ready low), Jy_Out and Out_Valid hold stable. No beats are accepted.
- Out_Ready while Out_Valid is low is ignored.
- Reset mid-node discards the partial sum. The first accepted beat after Reset deasserts is f_0.
- F_Valid high while F_Ready is low is not a transfer. The upstream stage holds F_Data.

## Configuration
- CY_MOMENT_SAT_EN defined: Jy_Out saturates to 0x7FFF_FFFF_FFFF_FFFF or 0x8000_0000_0000_0000 when acc exceeds the signed WIDTH range.
- CY_MOMENT_SAT_EN undefined: Jy_Out = acc[WIDTH-1:0], i.e. two's-complement wrap.
- All other behaviour is identical in both builds.

## Structure
- Shared package lbm_pkg holds:
  - the Q=9 and WIDTH=64 constants;
  - the Q8.56 constants FX_ONE (0x01_00000000000000), FX_NEG_ONE (0xFF_00000000000000) and FX_ZERO;
  - a cy_code_t enum {CY_ZERO, CY_POS, CY_NEG};
  - the state enum {ACCUM, HOLD}.
- Sub-module cy_decode: combinational; maps one WIDTH-bit entry to cy_code_t plus an illegal flag. It is instantiated once, on the entry selected by cnt.

## Test plan
- Decoded lattice, for the tests below: cy = {-1,-1,+1,+1,-1,0,+1,0,0} for i = 0..8, built from entries 0xFF,0xFF,0x01,0x01,0xFF,0x00,0x01,0x00,0x00 (integer byte, zero fraction).
- All f_i = 0x01_00000000000000, continuous F_Valid -> Jy_Out = 0, Out_Valid on cycle 10, Cy_Err = 0.
- f_i = i·1.0 (0x0i_000…) -> Jy_Out = 0x06_00000000000000.
- f_2 = f_3 = f_6 = 0x7FFF_FFFF_FFFF_FFFF, others 0 -> Jy_Out = 0x7FFF_FFFF_FFFF_FFFF with the macro, 0x7FFF_FFFF_FFFF_FFFD without it.
- Out_Ready held low 5 cycles after Out_Valid -> Jy_Out stable, F_Ready = 0 throughout, next node accepted only after the handshake.
- Reset pulsed after 4 beats -> all outputs 0 immediately; a following full node of all 1.0 gives Jy_Out = 0, with no stale partial sum.
- Cy_In entry 5 = 0x02_00000000000000 with all f_i = 1.0 -> Cy_Err = 1 and stays set; entry 5 contributes 0, so Jy_Out = 0.
